// File: rtl/alu_issue.sv
// alu_issue: in-order single-issue sequencer that feeds an ALU and a load/store port.
// Build macro ALU_ISSUE_SKIP_NOP_EN retires cond-failed ops straight from DECODE.
module alu_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [3:0]  cond,
  output logic [3:0]  opcode,
  output logic        sbit,
  output logic [2:0]  srcontrol,
  output logic [15:0] imvalue,
  output logic [3:0]  rd,
  output logic [3:0]  rn,
  output logic [3:0]  rm,
  output logic        alu_valid,
  output logic [3:0]  inflags,
  input  logic [3:0]  outflags,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        wb_en,
  output logic [31:0] pc
);

  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] DECODE = 3'd1;
  localparam logic [STATE_W-1:0] EXEC   = 3'd2;
  localparam logic [STATE_W-1:0] MEM    = 3'd3;
  localparam logic [STATE_W-1:0] WB     = 3'd4;

  localparam logic [3:0]  OP_CMP  = 4'b1000;
  localparam logic [3:0]  OP_LDR  = 4'b1001;
  localparam logic [3:0]  OP_STR  = 4'b1010;
  localparam logic [3:0]  OP_NOP  = 4'b1111;
  localparam logic [31:0] PC_STEP = 32'd4;

  logic [STATE_W-1:0] state, next_state;
  logic [31:0] word;
  logic        cond_ok, cond_ok_d, cond_pass;
  logic [3:0]  smp_flags, smp_flags_d;
  logic        smp_valid, smp_valid_d;
  logic [31:0] pc_d;
  logic [3:0]  flags_d;
  logic        ready_d, alu_valid_d, mem_req_d, mem_we_d, wb_en_d, fields_on;
  logic [3:0]  cond_d, opcode_d, rd_d;
  logic        sbit_d;
  logic [2:0]  srcontrol_d;
  logic [15:0] imvalue_d;

  logic [3:0] w_cond, w_op;
  logic       w_sbit, w_mem_op, w_wb_op, w_unused_op, w_flag_op;
  logic       f_n, f_z, f_c, f_v;

  assign w_cond      = word[31:28];
  assign w_op        = word[27:24];
  assign w_sbit      = word[23];
  assign w_mem_op    = (w_op == OP_LDR) || (w_op == OP_STR);
  assign w_wb_op     = !w_op[3] || (w_op == OP_LDR);
  assign w_unused_op = (w_op >= 4'b1011) && (w_op <= 4'b1110);
  assign w_flag_op   = (w_op == OP_CMP) || (w_sbit && !w_unused_op);
  assign {f_n, f_z, f_c, f_v} = inflags;
  assign rn = imvalue[15:12];
  assign rm = imvalue[11:8];

  // Condition check against the architectural flags
  always_comb begin
    cond_pass = 1'b1;
    case (w_cond)
      4'b0001: cond_pass = f_z;
      4'b0010: cond_pass = !f_z && (f_n == f_v);
      4'b0011: cond_pass = (f_n != f_v);
      4'b0100: cond_pass = (f_n == f_v);
      4'b0101: cond_pass = f_z || (f_n != f_v);
      4'b0110: cond_pass = f_c && !f_z;
      4'b0111: cond_pass = !f_c;
      4'b1000: cond_pass = f_c;
      default: cond_pass = 1'b1;
    endcase
  end

  // Next state plus next values of every registered output
  always_comb begin
    next_state  = state;
    cond_ok_d   = cond_ok;
    smp_flags_d = smp_flags;
    smp_valid_d = smp_valid;
    pc_d        = pc;
    flags_d     = inflags;
    case (state)
      IDLE: begin
        if (instr_valid && instr_ready) next_state = DECODE;
      end
      DECODE: begin
        cond_ok_d   = cond_pass;
        smp_valid_d = 1'b0;
        if (cond_pass && w_mem_op) next_state = MEM;
`ifdef ALU_ISSUE_SKIP_NOP_EN
        else if (!cond_pass) begin
          next_state = IDLE;
          pc_d       = pc + PC_STEP;
        end
`endif
        else next_state = EXEC;
      end
      EXEC: begin
        next_state  = WB;
        smp_flags_d = outflags;
        smp_valid_d = 1'b1;
      end
      MEM: begin
        if (mem_ack) next_state = WB;
      end
      WB: begin
        next_state = IDLE;
        pc_d       = pc + PC_STEP;
        // Memory ops never pass through EXEC, so they carry no flag sample
        if (cond_ok && smp_valid && w_flag_op) flags_d = smp_flags;
      end
      default: next_state = IDLE;
    endcase

    fields_on   = (next_state == EXEC) || (next_state == MEM);
    ready_d     = (next_state == IDLE);
    alu_valid_d = (next_state == EXEC);
    mem_req_d   = (next_state == MEM);
    mem_we_d    = (next_state == MEM) && (w_op == OP_STR);
    wb_en_d     = (next_state == WB) && cond_ok_d && w_wb_op;
    cond_d      = fields_on ? w_cond : 4'd0;
    sbit_d      = fields_on ? w_sbit : 1'b0;
    srcontrol_d = fields_on ? word[22:20] : 3'd0;
    rd_d        = fields_on ? word[19:16] : 4'd0;
    imvalue_d   = fields_on ? word[15:0] : 16'd0;
    opcode_d    = 4'd0;
    if (fields_on) opcode_d = ((next_state == EXEC) && !cond_ok_d) ? OP_NOP : w_op;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      word        <= 32'd0;
      cond_ok     <= 1'b0;
      smp_flags   <= 4'd0;
      smp_valid   <= 1'b0;
      pc          <= 32'd0;
      inflags     <= 4'd0;
      instr_ready <= 1'b0;
      alu_valid   <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      wb_en       <= 1'b0;
      cond        <= 4'd0;
      opcode      <= 4'd0;
      sbit        <= 1'b0;
      srcontrol   <= 3'd0;
      rd          <= 4'd0;
      imvalue     <= 16'd0;
    end else begin
      state       <= next_state;
      if ((state == IDLE) && instr_valid && instr_ready) word <= instr;
      cond_ok     <= cond_ok_d;
      smp_flags   <= smp_flags_d;
      smp_valid   <= smp_valid_d;
      pc          <= pc_d;
      inflags     <= flags_d;
      instr_ready <= ready_d;
      alu_valid   <= alu_valid_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      wb_en       <= wb_en_d;
      cond        <= cond_d;
      opcode      <= opcode_d;
      sbit        <= sbit_d;
      srcontrol   <= srcontrol_d;
      rd          <= rd_d;
      imvalue     <= imvalue_d;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: reset checks, a directed vector table, randomized ops against a
// transaction-level model, PC wrap and reset-abort sequences.
module tb_alu_issue;

`ifdef ALU_ISSUE_SKIP_NOP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk, reset, instr_valid, instr_ready;
  logic [31:0] instr;
  logic [3:0]  cond, opcode, rd, rn, rm, inflags, outflags;
  logic        sbit, alu_valid, mem_req, mem_we, mem_ack, wb_en;
  logic [2:0]  srcontrol;
  logic [15:0] imvalue;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  alu_issue dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .cond(cond), .opcode(opcode), .sbit(sbit), .srcontrol(srcontrol),
    .imvalue(imvalue), .rd(rd), .rn(rn), .rm(rm), .alu_valid(alu_valid),
    .inflags(inflags), .outflags(outflags), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .wb_en(wb_en), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] w;
    logic [3:0]  of;
    int          ackd;
    int          lat;
    int          n_alu;
    logic [3:0]  aop;
    int          n_wb;
    int          n_req;
    logic        we;
    logic [3:0]  flags;
    logic [31:0] pc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] w, input logic [3:0] of, input int ackd,
                              input int lat, input int n_alu, input logic [3:0] aop,
                              input int n_wb, input int n_req, input logic we,
                              input logic [3:0] fl, input logic [31:0] p);
    vec_t v;
    v.w = w; v.of = of; v.ackd = ackd; v.lat = lat; v.n_alu = n_alu; v.aop = aop;
    v.n_wb = n_wb; v.n_req = n_req; v.we = we; v.flags = fl; v.pc = p;
    return v;
  endfunction

  function automatic logic [31:0] iw(input logic [3:0] c, input logic [3:0] op, input logic s);
    return {c, op, s, 3'b101, 4'h6, 16'hA5C3};
  endfunction

  // Architectural condition rules on {N,Z,C,V}
  function automatic logic m_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd1: return z;
      4'd2: return !z && (n == v);
      4'd3: return n != v;
      4'd4: return n == v;
      4'd5: return z || (n != v);
      4'd6: return cf && !z;
      4'd7: return !cf;
      4'd8: return cf;
      default: return 1'b1;
    endcase
  endfunction

  // Whole-instruction outcome: latency, strobes and new architectural state
  function automatic vec_t model(input logic [31:0] w, input logic [3:0] of, input int ackd,
                                 input logic [3:0] fl, input logic [31:0] p);
    vec_t v;
    logic pass;
    int unsigned op;
    op   = int'(w[27:24]);
    pass = m_pass(w[31:28], fl);
    v = mk(w, of, ackd, 4, 0, 4'h0, 0, 0, 1'b0, fl, p + 32'd4);
    if (pass && (op == 9 || op == 10)) begin
      v.lat   = 3 + ackd;
      v.n_req = ackd;
      v.we    = (op == 10);
      v.n_wb  = (op == 9) ? 1 : 0;
    end else if (!pass && SKIP) begin
      v.lat = 2;
    end else begin
      v.n_alu = 1;
      v.aop   = pass ? w[27:24] : 4'hF;
      v.n_wb  = (pass && op <= 7) ? 1 : 0;
      if (pass && (op == 8 || (w[23] && !(op >= 11 && op <= 14)))) v.flags = of;
    end
    return v;
  endfunction

  task automatic issue(input logic [31:0] w, input logic [3:0] of, input int ackd,
                       output int lat, output int n_alu, output logic [3:0] aop,
                       output int n_wb, output int n_req, output logic we,
                       output logic [27:0] fld, output logic [7:0] rnrm);
    lat = 0; n_alu = 0; aop = 4'h0; n_wb = 0; n_req = 0; we = 1'b0; fld = '0; rnrm = '0;
    for (int i = 0; i < 20 && !instr_ready; i++) step;
    instr = w; instr_valid = 1'b1; mem_ack = 1'b0;
    step;
    instr_valid = 1'b0;
    instr = $urandom;
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      if (alu_valid) begin
        n_alu++;
        aop  = opcode;
        fld  = {cond, sbit, srcontrol, rd, imvalue};
        rnrm = {rn, rm};
      end
      if (wb_en) n_wb++;
      outflags = alu_valid ? of : 4'($urandom);
      if (mem_req) begin
        n_req++;
        we = we | mem_we;
        mem_ack = (n_req == ackd);
      end else begin
        mem_ack = 1'($urandom);
      end
      if (instr_ready) break;
      step;
      lat++;
    end
    mem_ack = 1'b0;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    int lat, n_alu, n_wb, n_req;
    logic [3:0] aop;
    logic we;
    logic [27:0] fld;
    logic [7:0] rnrm;
    issue(v.w, v.of, v.ackd, lat, n_alu, aop, n_wb, n_req, we, fld, rnrm);
    chk({tag, "_latency"}, 32'(lat), 32'(v.lat));
    chk({tag, "_alu_valid_cycles"}, 32'(n_alu), 32'(v.n_alu));
    chk({tag, "_alu_opcode"}, 32'(aop), 32'(v.aop));
    chk({tag, "_wb_en_pulses"}, 32'(n_wb), 32'(v.n_wb));
    chk({tag, "_mem_req_cycles"}, 32'(n_req), 32'(v.n_req));
    chk({tag, "_mem_we"}, 32'(we), 32'(v.we));
    chk({tag, "_flags"}, 32'(inflags), 32'(v.flags));
    chk({tag, "_pc"}, pc, v.pc);
    if (v.n_alu == 1) begin
      chk({tag, "_exec_fields"}, 32'(fld), 32'({v.w[31:28], v.w[23:0]}));
      chk({tag, "_rn_rm"}, 32'(rnrm), 32'(v.w[15:8]));
    end
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    logic [3:0]  m_fl;
    logic [31:0] m_pc;
    logic [31:0] w;

    reset = 1'b0; instr_valid = 1'b0; instr = '0; outflags = '0; mem_ack = 1'b0;
    repeat (3) step;
    chk("rst_instr_ready", 32'(instr_ready), 32'd0);
    chk("rst_strobes", 32'({alu_valid, mem_req, mem_we, wb_en}), 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_flags", 32'(inflags), 32'd0);
    chk("rst_fields", 32'({cond, opcode, sbit, srcontrol, rd, rn, rm}), 32'd0);
    chk("rst_imvalue", 32'(imvalue), 32'd0);
    reset = 1'b1;
    step;
    chk("ready_after_reset", 32'(instr_ready), 32'd1);

    // Reset while a load waits in MEM aborts it with no retirement
    instr = iw(4'h0, 4'h9, 1'b0); instr_valid = 1'b1;
    step;
    instr_valid = 1'b0;
    step;
    chk("abort_mem_req_before", 32'(mem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_wb_en", 32'(wb_en), 32'd0);
    chk("abort_pc", pc, 32'd0);
    chk("abort_flags", 32'(inflags), 32'd0);
    step;
    chk("abort_wb_en_later", 32'(wb_en), 32'd0);
    reset = 1'b1;
    step;
    chk("abort_ready_after", 32'(instr_ready), 32'd1);
    chk("abort_pc_after", pc, 32'd0);

    // w, outflags, ack delay, latency, alu cycles, alu opcode, wb, mem_req cycles, we, flags, pc
    tbl.push_back(mk(iw(4'h0, 4'h0, 1'b1), 4'h4, 1, 4, 1, 4'h0, 1, 0, 1'b0, 4'h4, 32'd4));
    tbl.push_back(mk(iw(4'h0, 4'h0, 1'b1), 4'h0, 1, 4, 1, 4'h0, 1, 0, 1'b0, 4'h0, 32'd8));
    tbl.push_back(mk(iw(4'h1, 4'h0, 1'b1), 4'h4, 1, SKIP ? 2 : 4, SKIP ? 0 : 1,
                     SKIP ? 4'h0 : 4'hF, 0, 0, 1'b0, 4'h0, 32'd12));
    tbl.push_back(mk(iw(4'h0, 4'h9, 1'b0), 4'h0, 3, 6, 0, 4'h0, 1, 3, 1'b0, 4'h0, 32'd16));
    tbl.push_back(mk(iw(4'h0, 4'hA, 1'b0), 4'h0, 1, 4, 0, 4'h0, 0, 1, 1'b1, 4'h0, 32'd20));
    tbl.push_back(mk(iw(4'h0, 4'h8, 1'b0), 4'h8, 1, 4, 1, 4'h8, 0, 0, 1'b0, 4'h8, 32'd24));
    tbl.push_back(mk(iw(4'h3, 4'h0, 1'b0), 4'h3, 1, 4, 1, 4'h0, 1, 0, 1'b0, 4'h8, 32'd28));
    tbl.push_back(mk(iw(4'h0, 4'hC, 1'b1), 4'h5, 1, 4, 1, 4'hC, 0, 0, 1'b0, 4'h8, 32'd32));
    tbl.push_back(mk(iw(4'h1, 4'h9, 1'b0), 4'h0, 1, SKIP ? 2 : 4, SKIP ? 0 : 1,
                     SKIP ? 4'h0 : 4'hF, 0, 0, 1'b0, 4'h8, 32'd36));
    tbl.push_back(mk(iw(4'h6, 4'h1, 1'b1), 4'hF, 1, SKIP ? 2 : 4, SKIP ? 0 : 1,
                     SKIP ? 4'h0 : 4'hF, 0, 0, 1'b0, 4'h8, 32'd40));
    tbl.push_back(mk(iw(4'h7, 4'h2, 1'b1), 4'h2, 1, 4, 1, 4'h2, 1, 0, 1'b0, 4'h2, 32'd44));
    tbl.push_back(mk(iw(4'h8, 4'h3, 1'b1), 4'h0, 1, 4, 1, 4'h3, 1, 0, 1'b0, 4'h0, 32'd48));
    for (int i = 0; i < tbl.size(); i++) check_vec($sformatf("vec%0d", i), tbl[i]);

    m_fl = 4'h0;
    m_pc = 32'd48;
    for (int i = 0; i < 150; i++) begin
      w = $urandom;
      w[31:28] = 4'($urandom_range(0, 9));
      v = model(w, 4'($urandom), int'($urandom_range(1, 4)), m_fl, m_pc);
      check_vec($sformatf("rnd%0d", i), v);
      m_fl = v.flags;
      m_pc = v.pc;
    end

    // PC wrap from the last word-aligned address
    force dut.pc = 32'hFFFF_FFFC;
    #1;
    release dut.pc;
    v = model(iw(4'h0, 4'h0, 1'b0), 4'h0, 1, m_fl, 32'hFFFF_FFFC);
    check_vec("wrap", v);
    chk("wrap_pc_zero", pc, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
